imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters: the pipeline IF stage and a debug/trace read port.
- Drives the ROM chip-enable and address, registers the returned word, and presents a 1-cycle-latency response to whichever requester was granted.
- The IF stage has priority. A starvation counter guarantees the debug port forward progress.
- Raises a stall request to pipeline control whenever the fetch is not serviced.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles debug may wait before it is force-granted one cycle; legal range 1..15.
- ADDR_W, 32: instruction address width; matches `INST_ADDR_BUS.
- DATA_W, 32: instruction word width; matches `INST_BUS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- if_req_i  in  1  IF stage requests a fetch this cycle.
- if_addr_i  in  ADDR_W  fetch address (PC).
- flush_i  in  1  pipeline flush; kills an in-flight fetch response.
- if_valid_o  out  1  fetch response valid (the cycle after the grant).
- if_data_o  out  DATA_W  fetched instruction.
- stall_req_o  out  1  fetch requested but not granted this cycle.
- dbg_req_i  in  1  debug read request; held high until dbg_valid_o.
- dbg_addr_i  in  ADDR_W  debug read address.
- dbg_valid_o  out  1  debug response valid.
- dbg_data_o  out  DATA_W  debug read data.
- dbg_err_o  out  1  with dbg_valid_o: address was misaligned.
- rom_ce_o  out  1  ROM chip enable (`CHIP_ENABLE / `CHIP_DISABLE).
- rom_addr_o  out  ADDR_W  ROM address.
- rom_data_i  in  DATA_W  ROM read data (combinational from rom_addr_o).

Behaviour:
- Reset (rst==0 at clk edge):
  - if_valid_o, dbg_valid_o, dbg_err_o = 0; if_data_o, dbg_data_o = `ZERO_WORD.
  - Starve counter = 0; FSM = ARB_NORMAL.
  - The combinational outputs rom_ce_o = `CHIP_DISABLE and stall_req_o = 0 while rst==0.
- A reset asserted mid-operation drops any in-flight response: valid does not appear on the following cycle.
- FSM states: ARB_NORMAL and ARB_DBG_FORCE.
- Grant in ARB_NORMAL:
  - if_req_i high: grant IF.
  - Otherwise, dbg_req_i high: grant debug.
  - Otherwise: no grant, rom_ce_o = disabled.
- Grant in ARB_DBG_FORCE: grant debug regardless of if_req_i. stall_req_o = if_req_i.
- Starve counter:
  - Increments each cycle dbg_req_i is high and debug is not granted.
  - Clears on any debug grant or when dbg_req_i is low.
  - Saturates at 15.
  - The transition ARB_NORMAL -> ARB_DBG_FORCE occurs when counter == STARVE_LIMIT-1 and debug is denied. The next cycle is forced.
  - The transition ARB_DBG_FORCE -> ARB_NORMAL occurs unconditionally after one cycle. If dbg_req_i has dropped, the forced cycle performs no debug read and grants IF if requested.
- Combinational ROM drive:
  - rom_ce_o is enabled iff there is a grant.
  - rom_addr_o is the granted address with bits [1:0] forced to 0.
  - With no grant, rom_addr_o = 0.
- Responses (registered, latency exactly 1 cycle):
  - Granted IF: if_valid_o = !flush_i (sampled in the grant cycle); if_data_o = rom_data_i.
  - Granted debug: dbg_valid_o = 1; dbg_data_o = rom_data_i; dbg_err_o = |dbg_addr_i[1:0].
  - A misaligned debug read still completes, and dbg_data_o holds the word at the aligned address.
  - Valid outputs are single-cycle pulses.
  - Data outputs hold their last value when valid is low.
- stall_req_o = if_req_i && !IF-grant (combinational).
- Simultaneous requests: IF wins unless the FSM is in ARB_DBG_FORCE.
- flush_i with no IF grant has no effect.
- The debug requester must drop dbg_req_i in the cycle dbg_valid_o is high, or a new read is issued.
- An IF misaligned address is not checked; alignment is silently forced.

Decomposition:
- Add to DEFINE.v:
  - `ARB_NORMAL / `ARB_DBG_FORCE state encodings (1 bit).
  - `STARVE_CNT_BUS (3:0).
  - Reuse the existing `INST_ADDR_BUS, `INST_BUS, `ZERO_WORD, `CHIP_ENABLE/`CHIP_DISABLE.
- One natural sub-module, imem_starve_cnt: a saturating counter with inc/clr and a limit-hit output.
- Grant logic and response registers stay in imem_arbiter.

Test Plan:
- Reset: hold rst=0 two cycles with if_req_i=1, dbg_req_i=1 -> all valids 0, rom_ce_o disabled; release -> the first grant goes to IF.
- IF only: if_req_i=1, if_addr_i=0x14 -> rom_addr_o=0x14 in the same cycle; next cycle if_valid_o=1, if_data_o=0x24630004; stall_req_o=0.
- Contention/starvation with STARVE_LIMIT=4: if_req_i=1 continuously, dbg_req_i=1, dbg_addr_i=0x40:
  - cycles 0-3: IF granted.
  - cycle 4: debug granted, stall_req_o=1.
  - cycle 5: dbg_valid_o=1, dbg_data_o=0x8c270000; counter back to 0.
- Misaligned debug: dbg_addr_i=0x5E, no IF -> rom_addr_o=0x5C; next cycle dbg_valid_o=1, dbg_err_o=1, dbg_data_o=0x8ce80000.
- Flush: IF granted at 0x6C with flush_i=1 in the same cycle -> next cycle if_valid_o=0. Flush on a cycle with no grant -> no effect on a following fetch.
- Reset mid-transaction: debug granted at cycle N, rst=0 at cycle N+1 -> dbg_valid_o stays 0; the counter and FSM return to ARB_NORMAL.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
package imem_arbiter_pkg;

   typedef enum logic {
      ARB_NORMAL    = 1'b0,
      ARB_DBG_FORCE = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_DBG  = 2'd2
   } gnt_t;

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   localparam int STARVE_CNT_W = 4;
   localparam logic [STARVE_CNT_W-1:0] STARVE_CNT_MAX = '1;

   function automatic logic misaligned(input logic [1:0] lsb);
      return |lsb;
   endfunction

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating wait counter for the debug port; flags when the force threshold is reached.
module imem_starve_cnt
   import imem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT_M1 = STARVE_CNT_W'(STARVE_LIMIT - 1);

   logic [STARVE_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != STARVE_CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign limit_hit = (cnt == LIMIT_M1);

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the combinational instruction ROM between the IF stage and a debug read port.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              flush_i,
   output logic              if_valid_o,
   output logic [DATA_W-1:0] if_data_o,
   output logic              stall_req_o,
   input  logic              dbg_req_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic              dbg_valid_o,
   output logic [DATA_W-1:0] dbg_data_o,
   output logic              dbg_err_o,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i
);

   arb_state_t        state, state_nxt;
   gnt_t              gnt;
   logic              limit_hit;
   logic              cnt_inc, cnt_clr;

   logic              if_valid_p1, dbg_valid_p1, dbg_err_p1;
   logic [DATA_W-1:0] if_data_p1, dbg_data_p1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ARB_NORMAL;
      end else begin
         state <= state_nxt;
      end
   end

   // The forced debug cycle lasts exactly one cycle, whatever happens in it.
   always_comb begin
      state_nxt = ARB_NORMAL;
      if ((state == ARB_NORMAL) && dbg_req_i && (gnt != GNT_DBG) && limit_hit) begin
         state_nxt = ARB_DBG_FORCE;
      end
   end

   always_comb begin
      gnt = GNT_NONE;
      if (rst) begin
         if (state == ARB_DBG_FORCE) begin
            if (dbg_req_i)     gnt = GNT_DBG;
            else if (if_req_i) gnt = GNT_IF;
         end else begin
            if (if_req_i)       gnt = GNT_IF;
            else if (dbg_req_i) gnt = GNT_DBG;
         end
      end
   end

   assign cnt_inc = dbg_req_i && (gnt != GNT_DBG);
   assign cnt_clr = !dbg_req_i || (gnt == GNT_DBG);

   imem_starve_cnt #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (cnt_inc),
      .clr      (cnt_clr),
      .limit_hit(limit_hit)
   );

   always_comb begin
      rom_ce_o   = CHIP_DISABLE;
      rom_addr_o = '0;
      case (gnt)
         GNT_IF: begin
            rom_ce_o   = CHIP_ENABLE;
            rom_addr_o = {if_addr_i[ADDR_W-1:2], 2'b00};
         end
         GNT_DBG: begin
            rom_ce_o   = CHIP_ENABLE;
            rom_addr_o = {dbg_addr_i[ADDR_W-1:2], 2'b00};
         end
         default: ;
      endcase
   end

   assign stall_req_o = rst && if_req_i && (gnt != GNT_IF);

   // Stage p1: registered ROM response, one cycle after the grant.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if_valid_p1  <= 1'b0;
         if_data_p1   <= '0;
         dbg_valid_p1 <= 1'b0;
         dbg_data_p1  <= '0;
         dbg_err_p1   <= 1'b0;
      end else begin
         if_valid_p1  <= (gnt == GNT_IF) && !flush_i;
         dbg_valid_p1 <= (gnt == GNT_DBG);
         dbg_err_p1   <= (gnt == GNT_DBG) && misaligned(dbg_addr_i[1:0]);
         if (gnt == GNT_IF)  if_data_p1  <= rom_data_i;
         if (gnt == GNT_DBG) dbg_data_p1 <= rom_data_i;
      end
   end

   // A reset arriving while a response is pending suppresses that response.
   assign if_valid_o  = if_valid_p1 && rst;
   assign dbg_valid_o = dbg_valid_p1 && rst;
   assign dbg_err_o   = dbg_err_p1 && rst;
   assign if_data_o   = if_data_p1;
   assign dbg_data_o  = dbg_data_p1;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: per-cycle vector table plus a response scoreboard.
module tb_imem_arbiter;

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_IF   = 2'd1;
   localparam logic [1:0] G_DBG  = 2'd2;

   typedef struct packed {
      logic        rst;
      logic        if_req;
      logic [31:0] if_addr;
      logic        flush;
      logic        dbg_req;
      logic [31:0] dbg_addr;
      logic [1:0]  gnt;
      logic        stall;
   } vec_t;

   typedef struct packed {
      logic        if_valid;
      logic [31:0] if_data;
      logic        dbg_valid;
      logic [31:0] dbg_data;
      logic        dbg_err;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i, flush_i, dbg_req_i;
   logic [31:0] if_addr_i, dbg_addr_i;
   logic        if_valid_o, stall_req_o, dbg_valid_o, dbg_err_o, rom_ce_o;
   logic [31:0] if_data_o, dbg_data_o, rom_addr_o, rom_data_i;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          step_no = 0;
   vec_t        tbl[$];
   resp_t       rspq[$];
   logic [31:0] m_if_data, m_dbg_data;

   always #5 clk = ~clk;

   imem_arbiter #(
      .STARVE_LIMIT(4),
      .ADDR_W      (32),
      .DATA_W      (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req_i   (if_req_i),
      .if_addr_i  (if_addr_i),
      .flush_i    (flush_i),
      .if_valid_o (if_valid_o),
      .if_data_o  (if_data_o),
      .stall_req_o(stall_req_o),
      .dbg_req_i  (dbg_req_i),
      .dbg_addr_i (dbg_addr_i),
      .dbg_valid_o(dbg_valid_o),
      .dbg_data_o (dbg_data_o),
      .dbg_err_o  (dbg_err_o),
      .rom_ce_o   (rom_ce_o),
      .rom_addr_o (rom_addr_o),
      .rom_data_i (rom_data_i)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h14:  return 32'h24630004;
         32'h40:  return 32'h8c270000;
         32'h5C:  return 32'h8ce80000;
         default: return {~a[15:0], a[15:0]};
      endcase
   endfunction

   always_comb rom_data_i = rom_word(rom_addr_o);

   function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                               input logic fl, input logic dr, input logic [31:0] da,
                               input logic [1:0] g, input logic st);
      vec_t v;
      v.rst = r; v.if_req = ir; v.if_addr = ia; v.flush = fl;
      v.dbg_req = dr; v.dbg_addr = da; v.gnt = g; v.stall = st;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at step %0d: got %h, expected %h", name, step_no, act, exp);
      end
   endtask

   // One clock cycle: drive, check combinational and pending-response outputs, predict.
   task automatic step(input vec_t v);
      resp_t       e, r;
      logic [31:0] ea;
      rst        = v.rst;
      if_req_i   = v.if_req;
      if_addr_i  = v.if_addr;
      flush_i    = v.flush;
      dbg_req_i  = v.dbg_req;
      dbg_addr_i = v.dbg_addr;
      #4;
      if (rspq.size() > 0) begin
         e = rspq.pop_front();
         chk("if_valid",  {31'd0, if_valid_o},  {31'd0, e.if_valid & v.rst});
         chk("if_data",   if_data_o,            e.if_data);
         chk("dbg_valid", {31'd0, dbg_valid_o}, {31'd0, e.dbg_valid & v.rst});
         chk("dbg_data",  dbg_data_o,           e.dbg_data);
         chk("dbg_err",   {31'd0, dbg_err_o},   {31'd0, e.dbg_err & v.rst});
      end
      ea = (v.gnt == G_IF)  ? {v.if_addr[31:2], 2'b00} :
           (v.gnt == G_DBG) ? {v.dbg_addr[31:2], 2'b00} : 32'd0;
      chk("rom_ce",    {31'd0, rom_ce_o},    {31'd0, v.gnt != G_NONE});
      chk("rom_addr",  rom_addr_o,           ea);
      chk("stall_req", {31'd0, stall_req_o}, {31'd0, v.stall});
      r = '0;
      if (!v.rst) begin
         m_if_data  = 32'd0;
         m_dbg_data = 32'd0;
      end else begin
         if (v.gnt == G_IF)  m_if_data  = rom_word(ea);
         if (v.gnt == G_DBG) m_dbg_data = rom_word(ea);
         r.if_valid  = (v.gnt == G_IF) && !v.flush;
         r.dbg_valid = (v.gnt == G_DBG);
         r.dbg_err   = (v.gnt == G_DBG) && (v.dbg_addr[1:0] != 2'b00);
      end
      r.if_data  = m_if_data;
      r.dbg_data = m_dbg_data;
      rspq.push_back(r);
      step_no++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; if_req_i = 1'b0; flush_i = 1'b0; dbg_req_i = 1'b0;
      if_addr_i = '0; dbg_addr_i = '0;
      m_if_data = '0; m_dbg_data = '0;

      // rst, if_req, if_addr, flush, dbg_req, dbg_addr, grant, stall
      tbl.push_back(mk(0, 1, 32'h14, 0, 1, 32'h40, G_NONE, 0));
      tbl.push_back(mk(0, 1, 32'h14, 0, 1, 32'h40, G_NONE, 0));
      tbl.push_back(mk(1, 1, 32'h14, 0, 1, 32'h40, G_IF,   0));
      tbl.push_back(mk(1, 1, 32'h18, 0, 1, 32'h40, G_IF,   0));
      tbl.push_back(mk(1, 1, 32'h1C, 0, 1, 32'h40, G_IF,   0));
      tbl.push_back(mk(1, 1, 32'h20, 0, 1, 32'h40, G_IF,   0));
      tbl.push_back(mk(1, 1, 32'h24, 0, 1, 32'h40, G_DBG,  1));
      tbl.push_back(mk(1, 1, 32'h24, 0, 0, 32'h40, G_IF,   0));
      tbl.push_back(mk(1, 1, 32'h14, 0, 0, 32'h00, G_IF,   0));
      tbl.push_back(mk(1, 0, 32'h00, 0, 0, 32'h00, G_NONE, 0));
      tbl.push_back(mk(1, 0, 32'h00, 0, 1, 32'h5E, G_DBG,  0));
      tbl.push_back(mk(1, 0, 32'h00, 0, 0, 32'h00, G_NONE, 0));
      tbl.push_back(mk(1, 1, 32'h6C, 1, 0, 32'h00, G_IF,   0));
      tbl.push_back(mk(1, 0, 32'h00, 1, 0, 32'h00, G_NONE, 0));
      tbl.push_back(mk(1, 1, 32'h70, 0, 0, 32'h00, G_IF,   0));
      tbl.push_back(mk(1, 1, 32'h6E, 0, 0, 32'h00, G_IF,   0));
      tbl.push_back(mk(1, 0, 32'h00, 0, 0, 32'h00, G_NONE, 0));

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Reset while a debug response is in flight.
      step(mk(1, 0, 32'h00, 0, 1, 32'h80, G_DBG,  0));
      step(mk(0, 0, 32'h00, 0, 0, 32'h00, G_NONE, 0));
      step(mk(1, 0, 32'h00, 0, 0, 32'h00, G_NONE, 0));

      // Reset just as a forced cycle is due: the counter and FSM must start over.
      for (int i = 0; i < 4; i++) step(mk(1, 1, 32'h30 + 4*i, 0, 1, 32'h44, G_IF, 0));
      step(mk(0, 1, 32'h40, 0, 1, 32'h44, G_NONE, 0));
      for (int i = 0; i < 4; i++) step(mk(1, 1, 32'h50 + 4*i, 0, 1, 32'h44, G_IF, 0));
      step(mk(1, 1, 32'h60, 0, 1, 32'h44, G_DBG,  1));
      step(mk(1, 0, 32'h00, 0, 0, 32'h00, G_NONE, 0));

      // Forced cycle with debug request withdrawn: IF gets the slot.
      for (int i = 0; i < 4; i++) step(mk(1, 1, 32'h100 + 4*i, 0, 1, 32'h48, G_IF, 0));
      step(mk(1, 1, 32'h110, 0, 0, 32'h48, G_IF,   0));
      step(mk(1, 1, 32'h114, 0, 1, 32'h48, G_IF,   0));
      step(mk(1, 0, 32'h00,  0, 0, 32'h00, G_NONE, 0));
      step(mk(1, 0, 32'h00,  0, 0, 32'h00, G_NONE, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
